wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 5-stage pipeline, directly downstream of the execute/memory stage. Holds the EX/M→WB pipeline register, selects the write-back value (ALU result, memory data, immediate or input port), drives the register-file write port, and returns the write-back value and forwarding selects to the execute/memory stage. Also owns the architectural output port register and a retired-instruction counter.

## Interface
- none (datapath fixed at 16 bits, register address 3 bits)

- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_stall  in  1  hold WB register and suppress WB side effects this cycle
- i_flush  in  1  load a bubble into WB register at next edge
- i_valid  in  1  EX/M slot holds a real instruction
- i_write_back  in  1  instruction writes a register
- i_wb_selector  in  2  00 ex_result, 01 memory_data, 10 immediate, 11 input port
- i_write_addr  in  3  destination register
- i_ex_result  in  16  ALU/mov result from EX/M
- i_memory_data  in  16  data-memory read data from EX/M
- i_immediate  in  16  immediate passed through EX/M
- i_out_port  in  1  instruction is OUT (writes output port from ex_result path)
- i_input_port  in  16  external input port, sampled at capture
- i_exm_rs, i_exm_rd  in  3 each  source registers of the instruction now in EX/M
- i_exm_rs_used, i_exm_rd_used  in  1 each  those sources are actually read
- o_data_wb  out  16  selected write-back value (to reg file and EX/M forwarding)
- o_write_addr  out  3  reg-file write address
- o_write_enable  out  1  reg-file write strobe
- o_data1_forward, o_data2_forward  out  1 each  forwarding selects to EX/M
- o_output_port  out  16  architectural output port
- o_output_valid  out  1  one-cycle strobe when o_output_port updates
- o_retired  out  16  count of retired valid instructions

## Operation
- WB register fields: valid, write_back, wb_selector, write_addr, ex_result, memory_data, immediate, out_port, input_sample.
- Capture at rising edge: if i_flush → load bubble (valid, write_back, out_port = 0; data fields don't-care, driven 0); else if i_stall → hold; else load all inputs, input_sample ← i_input_port.
- i_flush and i_stall both high: flush wins.
- o_data_wb combinational mux of WB register by wb_selector (01 → memory_data, 11 → input_sample, etc.).
- o_write_enable = valid & write_back & ~i_stall; o_write_addr = WB write_addr.
- o_data1_forward = valid & write_back & i_exm_rs_used & (write_addr == i_exm_rs); o_data2_forward likewise with rd. Forwarding is NOT gated by stall (value is stable while held).
- Output port: at edge where valid & out_port & ~i_stall → o_output_port ← WB ex_result, o_output_valid ← 1; otherwise o_output_valid ← 0, port holds.
- Retire counter: increments at edge where valid & ~i_stall; wraps 0xFFFF → 0x0000.
- Reset (i_reset low, asynchronous): WB register cleared (bubble), o_output_port = 0, o_output_valid = 0, o_retired = 0; combinational outputs therefore o_data_wb = 0, o_write_enable = 0, forward selects = 0. Reset mid-stall discards held instruction.

## Timing
- Instruction in EX/M in cycle N → in WB during cycle N+1; o_data_wb/o_write_enable valid in N+1; reg-file write at edge ending N+1.
- Forward selects and o_data_wb valid in cycle N+1 for instruction in EX/M in N+1 (one-instruction distance).
- Stalled WB instruction completes (write, port, count) exactly once, in first cycle with i_stall low.
- o_output_valid is registered: high in cycle N+2 for an OUT in WB at N+1.
- Input port sampled at edge ending cycle N, not at WB time.

## Test plan
- Reset: drive i_reset=0 mid-traffic → all outputs 0 immediately (async), o_retired=0.
- Select mux: four back-to-back instrs to R1 with sel 00/01/10/11 and ex=0x1111, mem=0x2222, imm=0x3333, in_port=0x4444 → o_data_wb sequence 1111,2222,3333,4444, each with o_write_enable=1, addr=1.
- Forwarding: WB writes R3, EX/M rs=3 used, rd=3 unused → data1_forward=1, data2_forward=0; same with write_back=0 → both 0.
- Stall: OUT ex=0xBEEF held 3 stalled cycles → o_write_enable=0, port unchanged; on release single o_output_valid pulse, port=0xBEEF, o_retired +1 once.
- Flush+stall same cycle with valid input → WB becomes bubble, no write, counter unchanged.
- Counter wrap: preload via 65535 retirements → next retirement gives o_retired=0x0000.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: EX/M->WB pipeline register, write-back select, reg-file write port,
// forwarding selects back to EX/M, architectural output port and retired-instruction counter.
module wb_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic        i_write_back,
  input  logic [1:0]  i_wb_selector,
  input  logic [2:0]  i_write_addr,
  input  logic [15:0] i_ex_result,
  input  logic [15:0] i_memory_data,
  input  logic [15:0] i_immediate,
  input  logic        i_out_port,
  input  logic [15:0] i_input_port,
  input  logic [2:0]  i_exm_rs,
  input  logic [2:0]  i_exm_rd,
  input  logic        i_exm_rs_used,
  input  logic        i_exm_rd_used,
  output logic [15:0] o_data_wb,
  output logic [2:0]  o_write_addr,
  output logic        o_write_enable,
  output logic        o_data1_forward,
  output logic        o_data2_forward,
  output logic [15:0] o_output_port,
  output logic        o_output_valid,
  output logic [15:0] o_retired
);

  typedef struct packed {
    logic        valid;
    logic        write_back;
    logic [1:0]  wb_selector;
    logic [2:0]  write_addr;
    logic [15:0] ex_result;
    logic [15:0] memory_data;
    logic [15:0] immediate;
    logic        out_port;
    logic [15:0] input_sample;
  } wb_reg_t;

  wb_reg_t     wb_q, wb_d;
  logic [15:0] port_q, port_d;
  logic        port_vld_q, port_vld_d;
  logic [15:0] retired_q, retired_d;
  logic        complete;
  logic        writes_reg;

  // The instruction in WB takes effect only in a cycle it is not being held.
  assign complete   = wb_q.valid & ~i_stall;
  assign writes_reg = wb_q.valid & wb_q.write_back;

  always_comb begin
    wb_d = wb_q;
    if (i_flush) begin
      wb_d = '0;
    end else if (!i_stall) begin
      wb_d.valid        = i_valid;
      wb_d.write_back   = i_write_back;
      wb_d.wb_selector  = i_wb_selector;
      wb_d.write_addr   = i_write_addr;
      wb_d.ex_result    = i_ex_result;
      wb_d.memory_data  = i_memory_data;
      wb_d.immediate    = i_immediate;
      wb_d.out_port     = i_out_port;
      wb_d.input_sample = i_input_port;
    end

    retired_d  = retired_q + {15'd0, complete};
    port_d     = port_q;
    port_vld_d = 1'b0;
    if (complete && wb_q.out_port) begin
      port_d     = wb_q.ex_result;
      port_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wb_q       <= '0;
      port_q     <= '0;
      port_vld_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      wb_q       <= wb_d;
      port_q     <= port_d;
      port_vld_q <= port_vld_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    case (wb_q.wb_selector)
      2'b00:   o_data_wb = wb_q.ex_result;
      2'b01:   o_data_wb = wb_q.memory_data;
      2'b10:   o_data_wb = wb_q.immediate;
      default: o_data_wb = wb_q.input_sample;
    endcase
  end

  assign o_write_addr    = wb_q.write_addr;
  assign o_write_enable  = writes_reg & ~i_stall;
  // Held value is stable, so forwarding stays live during a stall.
  assign o_data1_forward = writes_reg & i_exm_rs_used & (wb_q.write_addr == i_exm_rs);
  assign o_data2_forward = writes_reg & i_exm_rd_used & (wb_q.write_addr == i_exm_rd);
  assign o_output_port   = port_q;
  assign o_output_valid  = port_vld_q;
  assign o_retired       = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: per-cycle reference model plus hand-computed literal checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        valid = 1'b0, wbk = 1'b0, outp = 1'b0;
  logic [1:0]  sel = '0;
  logic [2:0]  addr = '0, exm_rs = '0, exm_rd = '0;
  logic        rs_used = 1'b0, rd_used = 1'b0;
  logic [15:0] ex = '0, mem = '0, imm = '0, inport = '0;

  logic [15:0] data_wb, out_port_o, retired;
  logic [2:0]  waddr;
  logic        we, fwd1, fwd2, out_vld;

  int tests = 0;
  int fails = 0;

  wb_stage dut (
    .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_write_back(wbk), .i_wb_selector(sel), .i_write_addr(addr),
    .i_ex_result(ex), .i_memory_data(mem), .i_immediate(imm), .i_out_port(outp),
    .i_input_port(inport), .i_exm_rs(exm_rs), .i_exm_rd(exm_rd),
    .i_exm_rs_used(rs_used), .i_exm_rd_used(rd_used),
    .o_data_wb(data_wb), .o_write_addr(waddr), .o_write_enable(we),
    .o_data1_forward(fwd1), .o_data2_forward(fwd2),
    .o_output_port(out_port_o), .o_output_valid(out_vld), .o_retired(retired)
  );

  always #5 clk = ~clk;

  // Reference: the instruction sitting in WB, plus architectural port and retire count.
  logic        m_v = 0, m_wb = 0, m_out = 0, m_ov = 0;
  logic [1:0]  m_sel = 0;
  logic [2:0]  m_addr = 0;
  logic [15:0] m_ex = 0, m_mem = 0, m_imm = 0, m_in = 0, m_port = 0;
  int          m_ret = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 0; m_wb <= 0; m_out <= 0; m_sel <= 0; m_addr <= 0;
      m_ex <= 0; m_mem <= 0; m_imm <= 0; m_in <= 0;
      m_port <= 0; m_ov <= 0; m_ret <= 0;
    end else begin
      if (m_v && !stall) m_ret <= (m_ret + 1) % 65536;
      if (m_v && !stall && m_out) m_port <= m_ex;
      m_ov <= m_v && !stall && m_out;
      if (flush) begin
        m_v <= 0; m_wb <= 0; m_out <= 0; m_sel <= 0; m_addr <= 0;
        m_ex <= 0; m_mem <= 0; m_imm <= 0; m_in <= 0;
      end else if (!stall) begin
        m_v <= valid; m_wb <= wbk; m_out <= outp; m_sel <= sel; m_addr <= addr;
        m_ex <= ex; m_mem <= mem; m_imm <= imm; m_in <= inport;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] exp_data;
    logic        writes;
    case (m_sel)
      2'd0: exp_data = m_ex;
      2'd1: exp_data = m_mem;
      2'd2: exp_data = m_imm;
      default: exp_data = m_in;
    endcase
    writes = m_v && m_wb;
    chk("m_data_wb", data_wb, exp_data);
    chk("m_write_addr", {13'd0, waddr}, {13'd0, m_addr});
    chk("m_write_enable", {15'd0, we}, {15'd0, writes && !stall});
    chk("m_fwd1", {15'd0, fwd1}, {15'd0, writes && rs_used && (m_addr == exm_rs)});
    chk("m_fwd2", {15'd0, fwd2}, {15'd0, writes && rd_used && (m_addr == exm_rd)});
    chk("m_out_port", out_port_o, m_port);
    chk("m_out_valid", {15'd0, out_vld}, {15'd0, m_ov});
    chk("m_retired", retired, m_ret[15:0]);
  end

  task automatic set_instr(input logic v, input logic w, input logic [1:0] s,
                           input logic [2:0] a, input logic [15:0] e, input logic [15:0] m,
                           input logic [15:0] i, input logic o, input logic [15:0] p);
    valid = v; wbk = w; sel = s; addr = a; ex = e; mem = m; imm = i; outp = o; inport = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sel_exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_data", data_wb, 16'h0000);
    chk("rst_we", {15'd0, we}, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_port", out_port_o, 16'h0000);
    rst_n = 1'b1;

    // Select mux, back-to-back writes to R1
    for (int s = 0; s < 4; s++) begin
      set_instr(1, 1, s[1:0], 3'd1, 16'h1111, 16'h2222, 16'h3333, 0, 16'h4444);
      step();
      chk("mux_data", data_wb, sel_exp[s]);
      chk("mux_we", {15'd0, we}, 16'h0001);
      chk("mux_addr", {13'd0, waddr}, 16'h0001);
    end

    // Forwarding
    set_instr(1, 1, 0, 3'd3, 16'h5555, 0, 0, 0, 0);
    step();
    exm_rs = 3'd3; rs_used = 1; exm_rd = 3'd3; rd_used = 0;
    #1;
    chk("fwd_rs", {15'd0, fwd1}, 16'h0001);
    chk("fwd_rd_unused", {15'd0, fwd2}, 16'h0000);
    set_instr(1, 0, 0, 3'd3, 16'h5555, 0, 0, 0, 0);
    step();
    chk("fwd_nowb_rs", {15'd0, fwd1}, 16'h0000);
    chk("fwd_nowb_rd", {15'd0, fwd2}, 16'h0000);
    rs_used = 0;
    chk("retired_before_out", retired, 16'd5);

    // OUT held by three stalled cycles
    set_instr(1, 1, 0, 3'd4, 16'hBEEF, 0, 0, 1, 0);
    step();
    stall = 1;
    set_instr(1, 1, 0, 3'd5, 16'h1234, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_we", {15'd0, we}, 16'h0000);
      chk("stall_port", out_port_o, 16'h0000);
      chk("stall_ov", {15'd0, out_vld}, 16'h0000);
      chk("stall_retired", retired, 16'd6);
      step();
    end
    stall = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("release_ov", {15'd0, out_vld}, 16'h0001);
    chk("release_port", out_port_o, 16'hBEEF);
    chk("release_retired", retired, 16'd7);
    step();
    chk("after_ov", {15'd0, out_vld}, 16'h0000);
    chk("after_retired", retired, 16'd7);

    // Flush and stall together discard both instructions
    set_instr(1, 1, 0, 3'd2, 16'h7777, 0, 0, 0, 0);
    step();
    flush = 1; stall = 1;
    set_instr(1, 1, 0, 3'd6, 16'h9999, 0, 0, 0, 0);
    step();
    flush = 0; stall = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_we", {15'd0, we}, 16'h0000);
    chk("flush_data", data_wb, 16'h0000);
    chk("flush_retired", retired, 16'd7);
    step();
    chk("flush_retired2", retired, 16'd7);

    // Asynchronous reset mid-traffic, during a stall
    set_instr(1, 1, 0, 3'd7, 16'hABCD, 0, 0, 0, 0);
    step();
    step();
    chk("pre_rst_retired", retired, 16'd8);
    stall = 1;
    #1 rst_n = 0;
    #1;
    chk("arst_data", data_wb, 16'h0000);
    chk("arst_we", {15'd0, we}, 16'h0000);
    chk("arst_port", out_port_o, 16'h0000);
    chk("arst_retired", retired, 16'h0000);
    step();
    rst_n = 1; stall = 0;

    // Counter wrap: first edge loads, then 65535 retirements
    set_instr(1, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
    repeat (65536) step();
    chk("wrap_max", retired, 16'hFFFF);
    step();
    chk("wrap_zero", retired, 16'h0000);

    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
